// File: rtl/pipeline_control.sv
// Pipeline register enables and bubble controls derived from hazard, branch,
// cache-miss and HLT inputs, with saturating stall/flush performance counters.
module pipeline_control #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             d_halt,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DW-1:0]    r_drain;
  logic [DW-1:0]    w_drain_next;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_we, w_idex_flush;
  logic w_exmem_we, w_memwb_we;
  logic w_flush_applied;
  logic w_stall_inc;

  always_comb begin
    w_state_next    = r_state;
    w_drain_next    = r_drain;
    w_pc_we         = 1'b0;
    w_ifid_we       = 1'b0;
    w_ifid_flush    = 1'b0;
    w_idex_we       = 1'b0;
    w_idex_flush    = 1'b0;
    w_exmem_we      = 1'b0;
    w_memwb_we      = 1'b0;
    w_flush_applied = 1'b0;
    case (r_state)
      // DWAIT re-enters the RUN rules in the first cycle the miss clears
      RUN, DWAIT: begin
        if (dcache_miss) begin
          w_state_next = DWAIT;
        end else if (stall) begin
          w_state_next = RUN;
          w_idex_we    = 1'b1;
          w_idex_flush = 1'b1;
          w_exmem_we   = 1'b1;
          w_memwb_we   = 1'b1;
        end else begin
          w_state_next = RUN;
          w_pc_we      = 1'b1;
          w_ifid_we    = 1'b1;
          w_idex_we    = 1'b1;
          w_exmem_we   = 1'b1;
          w_memwb_we   = 1'b1;
          if (flush) begin
            w_ifid_flush    = 1'b1;
            w_flush_applied = 1'b1;
          end
          if (d_halt) begin
            w_pc_we      = 1'b0;
            w_ifid_flush = 1'b1;
            w_state_next = DRAIN;
            w_drain_next = DRAIN_INIT;
          end else if (!flush && icache_miss) begin
            w_pc_we      = 1'b0;
            w_ifid_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        w_ifid_flush = 1'b1;
        if (!dcache_miss) begin
          w_ifid_we  = 1'b1;
          w_idex_we  = 1'b1;
          w_exmem_we = 1'b1;
          w_memwb_we = 1'b1;
          if (r_drain == '0) begin
            w_state_next = HALTED;
          end else begin
            w_drain_next = r_drain - DW'(1);
          end
        end
      end
      default: begin
        w_state_next = HALTED;
      end
    endcase
  end

  assign w_stall_inc = (r_state == RUN) && !w_pc_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_drain        <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_drain <= w_drain_next;
      if (w_stall_inc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_applied && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  // Controls are forced low while reset is asserted so nothing latches garbage
  assign pc_we        = rst_n & w_pc_we;
  assign ifid_we      = rst_n & w_ifid_we;
  assign ifid_flush   = rst_n & w_ifid_flush;
  assign idex_we      = rst_n & w_idex_we;
  assign idex_flush   = rst_n & w_idex_flush;
  assign exmem_we     = rst_n & w_exmem_we;
  assign memwb_we     = rst_n & w_memwb_we;
  assign halted       = rst_n & (r_state == HALTED);
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
